uart_tx_mux_2_a_1: RTL and testbench

//  Merges two byte sources (channel 1 / channel 2) into the single UART transmitter; transmit-side counterpart of the RX demux.

---
 rtl/uart_tx_mux_2_a_1.sv | 87 ++++++++
 tb/tb_uart_tx_mux_2_a_1.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mux_2_a_1.sv
// uart_tx_mux_2_a_1: round-robin merge of two one-byte holding registers onto a single UART transmitter.
module uart_tx_mux_2_a_1 #(
    parameter int DATA_W       = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wr1_i,
    input  logic [DATA_W-1:0] data1_i,
    output logic              full1_o,
    output logic              ovf1_o,
    input  logic              wr2_i,
    input  logic [DATA_W-1:0] data2_i,
    output logic              full2_o,
    output logic              ovf2_o,
    input  logic              ovf_clr_i,
    output logic              tx_start_o,
    output logic [DATA_W-1:0] tx_data_o,
    input  logic              tx_busy_i,
    output logic              sel_o,
    output logic              err_o
);
    localparam int CW = $clog2(BUSY_TIMEOUT);

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] hold1, hold2;
    logic [CW-1:0]     cnt;
    logic              last_grant;
    logic              g1, g2, timeout;

    // On a tie the channel not served last wins
    assign g1      = (state == IDLE) && full1_o && (!full2_o || last_grant);
    assign g2      = (state == IDLE) && full2_o && (!full1_o || !last_grant);
    assign timeout = (state == WAIT_BUSY) && !tx_busy_i && (cnt == CW'(BUSY_TIMEOUT - 1));
    assign tx_start_o = (state == START);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = (g1 || g2) ? START : IDLE;
            START:     state_n = WAIT_BUSY;
            WAIT_BUSY: state_n = tx_busy_i ? WAIT_DONE : (timeout ? IDLE : WAIT_BUSY);
            WAIT_DONE: state_n = tx_busy_i ? WAIT_DONE : IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            hold1      <= '0;
            hold2      <= '0;
            full1_o    <= 1'b0;
            full2_o    <= 1'b0;
            ovf1_o     <= 1'b0;
            ovf2_o     <= 1'b0;
            tx_data_o  <= '0;
            sel_o      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            err_o      <= 1'b0;
        end else begin
            state   <= state_n;
            err_o   <= timeout;
            // A write into an occupied register is dropped even if that register is granted this edge
            full1_o <= (full1_o && !g1) || (wr1_i && !full1_o);
            full2_o <= (full2_o && !g2) || (wr2_i && !full2_o);
            ovf1_o  <= (wr1_i && full1_o) || (ovf1_o && !ovf_clr_i);
            ovf2_o  <= (wr2_i && full2_o) || (ovf2_o && !ovf_clr_i);
            if (wr1_i && !full1_o)
                hold1 <= data1_i;
            if (wr2_i && !full2_o)
                hold2 <= data2_i;
            if (g1 || g2) begin
                tx_data_o  <= g1 ? hold1 : hold2;
                sel_o      <= g2;
                last_grant <= g2;
            end
            if (state == START)
                cnt <= '0;
            else if (state == WAIT_BUSY && !tx_busy_i)
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_tx_mux_2_a_1.sv
// tb_uart_tx_mux_2_a_1: directed bench for the two-channel UART transmit merger.
module tb_uart_tx_mux_2_a_1;
    localparam int DATA_W       = 8;
    localparam int BUSY_TIMEOUT = 16;

    logic              clk_i = 1'b0;
    logic              rst_n_i = 1'b0;
    logic              wr1_i = 1'b0, wr2_i = 1'b0, ovf_clr_i = 1'b0, tx_busy_i = 1'b0;
    logic [DATA_W-1:0] data1_i = '0, data2_i = '0;
    logic              full1_o, ovf1_o, full2_o, ovf2_o, tx_start_o, sel_o, err_o;
    logic [DATA_W-1:0] tx_data_o;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    always #5 clk_i = ~clk_i;

    uart_tx_mux_2_a_1 #(.DATA_W(DATA_W), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .wr1_i(wr1_i), .data1_i(data1_i), .full1_o(full1_o), .ovf1_o(ovf1_o),
        .wr2_i(wr2_i), .data2_i(data2_i), .full2_o(full2_o), .ovf2_o(ovf2_o),
        .ovf_clr_i(ovf_clr_i), .tx_start_o(tx_start_o), .tx_data_o(tx_data_o),
        .tx_busy_i(tx_busy_i), .sel_o(sel_o), .err_o(err_o)
    );

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        wr1_i = 1'b0; wr2_i = 1'b0; ovf_clr_i = 1'b0; tx_busy_i = 1'b0;
        tick(2);
        rst_n_i = 1'b1;
    endtask

    // Waits (bounded) for the start strobe, checks the byte, then plays a busy frame of busy_cycles
    task automatic expect_frame(string tag, logic [7:0] d, logic s, int busy_cycles);
        int k = 0;
        while (tx_start_o !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        chk({tag, "_start"}, tx_start_o, 1);
        chk({tag, "_data"}, tx_data_o, d);
        chk({tag, "_sel"}, sel_o, s);
        tx_busy_i = 1'b1;
        tick();
        chk({tag, "_pulse"}, tx_start_o, 0);
        tick(busy_cycles - 1);
        tx_busy_i = 1'b0;
    endtask

    initial begin
        int k;
        logic started;
        #2;
        chk("rst_full1", full1_o, 0);
        chk("rst_start", tx_start_o, 0);
        chk("rst_data", tx_data_o, 0);
        chk("rst_sel", sel_o, 0);
        chk("rst_err", err_o, 0);
        tick(2);
        rst_n_i = 1'b1;

        // T1 single byte
        wr1_i = 1'b1; data1_i = 8'hA5;
        tick();
        wr1_i = 1'b0;
        chk("t1_full", full1_o, 1);
        chk("t1_nostart", tx_start_o, 0);
        tick();
        chk("t1_freed", full1_o, 0);
        expect_frame("t1", 8'hA5, 1'b0, 10);
        tick();
        chk("t1_idle", tx_start_o, 0);
        chk("t1_hold", tx_data_o, 8'hA5);
        chk("t1_err", err_o, 0);

        // T2 tie and round robin
        do_reset();
        wr1_i = 1'b1; data1_i = 8'h11; wr2_i = 1'b1; data2_i = 8'h22;
        tick();
        wr1_i = 1'b0; wr2_i = 1'b0;
        chk("t2_full1", full1_o, 1);
        chk("t2_full2", full2_o, 1);
        expect_frame("t2a", 8'h11, 1'b0, 3);
        expect_frame("t2b", 8'h22, 1'b1, 3);
        tick();
        wr1_i = 1'b1; data1_i = 8'h33; wr2_i = 1'b1; data2_i = 8'h44;
        tick();
        wr1_i = 1'b0; wr2_i = 1'b0;
        expect_frame("t2c", 8'h33, 1'b0, 3);
        expect_frame("t2d", 8'h44, 1'b1, 3);

        // T3 overflow, dropped on the grant edge; then set-wins over clear
        do_reset();
        wr2_i = 1'b1; data2_i = 8'h55;
        tick();
        data2_i = 8'h66;
        tick();
        wr2_i = 1'b0;
        chk("t3_ovf2", ovf2_o, 1);
        chk("t3_full2", full2_o, 0);
        expect_frame("t3", 8'h55, 1'b1, 3);
        tick(3);
        chk("t3_no66_start", tx_start_o, 0);
        chk("t3_no66_full", full2_o, 0);
        chk("t3_no66_data", tx_data_o, 8'h55);
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        chk("t3_clr", ovf2_o, 0);
        wr1_i = 1'b1; data1_i = 8'h12;
        tick();
        data1_i = 8'h13; ovf_clr_i = 1'b1;
        tick();
        wr1_i = 1'b0; ovf_clr_i = 1'b0;
        chk("t3_setwins", ovf1_o, 1);
        expect_frame("t3b", 8'h12, 1'b0, 3);

        // T4 busy timeout: err_o follows BUSY_TIMEOUT cycles after the strobe ends
        do_reset();
        wr1_i = 1'b1; data1_i = 8'h88; wr2_i = 1'b1; data2_i = 8'h77;
        tick();
        wr1_i = 1'b0; wr2_i = 1'b0;
        tick();
        chk("t4_start", tx_start_o, 1);
        chk("t4_data", tx_data_o, 8'h88);
        k = 0;
        while (err_o !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        chk("t4_err_delay", k, BUSY_TIMEOUT + 1);
        chk("t4_err_nostart", tx_start_o, 0);
        tick();
        chk("t4_err_pulse", err_o, 0);
        expect_frame("t4b", 8'h77, 1'b1, 4);

        // T5 reset in WAIT_DONE with both registers full
        do_reset();
        wr1_i = 1'b1; data1_i = 8'hA1; wr2_i = 1'b1; data2_i = 8'hB2;
        tick();
        wr1_i = 1'b0; wr2_i = 1'b0;
        tick();
        tx_busy_i = 1'b1;
        tick(2);
        wr1_i = 1'b1; data1_i = 8'hC3;
        tick();
        wr1_i = 1'b0;
        chk("t5_full1", full1_o, 1);
        chk("t5_full2", full2_o, 1);
        rst_n_i = 1'b0;
        #2;
        chk("t5_async_full1", full1_o, 0);
        chk("t5_async_full2", full2_o, 0);
        chk("t5_async_data", tx_data_o, 0);
        chk("t5_async_sel", sel_o, 0);
        chk("t5_async_start", tx_start_o, 0);
        tx_busy_i = 1'b0;
        tick(2);
        rst_n_i = 1'b1;
        started = 1'b0;
        repeat (6) begin
            tick();
            if (tx_start_o) started = 1'b1;
        end
        chk("t5_quiet", started, 0);

        // T6 refill while the previous byte is in flight
        do_reset();
        wr1_i = 1'b1; data1_i = 8'h01;
        tick();
        wr1_i = 1'b0;
        tick();
        chk("t6_start1", tx_start_o, 1);
        chk("t6_data1", tx_data_o, 8'h01);
        tx_busy_i = 1'b1;
        tick();
        wr1_i = 1'b1; data1_i = 8'h02;
        tick();
        wr1_i = 1'b0;
        chk("t6_refill", full1_o, 1);
        chk("t6_noovf", ovf1_o, 0);
        tick(3);
        tx_busy_i = 1'b0;
        tick();
        chk("t6_idle_gap", tx_start_o, 0);
        tick();
        chk("t6_start2", tx_start_o, 1);
        chk("t6_data2", tx_data_o, 8'h02);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
